// File: rtl/write_back_regfile.sv
// Write-back stage register file: source mux, 2 async read ports, registered forwarding copy.
// Optional macro WB_BYPASS_EN makes same-cycle reads of the write address return the new value.
module write_back_regfile #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [DATA_W-1:0] i_ex_result,
    input  logic [DATA_W-1:0] i_memory_data,
    input  logic [DATA_W-1:0] i_immediate,
    input  logic [DATA_W-1:0] i_port,
    input  logic [1:0]        i_wb_selector,
    input  logic              i_write_back,
    input  logic [ADDR_W-1:0] i_write_addr,
    input  logic [ADDR_W-1:0] i_read_addr_a,
    input  logic [ADDR_W-1:0] i_read_addr_b,
    output logic [DATA_W-1:0] o_read_data_a,
    output logic [DATA_W-1:0] o_read_data_b,
    output logic [DATA_W-1:0] o_wb_data,
    output logic              o_fwd_valid,
    output logic [ADDR_W-1:0] o_fwd_addr,
    output logic [DATA_W-1:0] o_fwd_data
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_reg [DEPTH];
    logic [DATA_W-1:0] wb_data_next;
    logic              fwd_valid_reg;
    logic [ADDR_W-1:0] fwd_addr_reg;
    logic [DATA_W-1:0] fwd_data_reg;

    always_comb begin
        wb_data_next = i_ex_result;
        case (i_wb_selector)
            2'b00:   wb_data_next = i_ex_result;
            2'b01:   wb_data_next = i_memory_data;
            2'b10:   wb_data_next = i_immediate;
            default: wb_data_next = i_port;
        endcase
    end

    assign o_wb_data = wb_data_next;

    // Per-register write logic; the reset clear keeps the array in fabric flops.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_reg
            always_ff @(posedge i_clk) begin
                if (i_reset) begin
                    regs_reg[gi] <= '0;
                end else if (i_write_back && (i_write_addr == ADDR_W'(gi))) begin
                    regs_reg[gi] <= wb_data_next;
                end
            end
        end
    endgenerate

`ifdef WB_BYPASS_EN
    logic write_now;
    assign write_now = i_write_back && !i_reset;

    always_comb begin
        o_read_data_a = regs_reg[i_read_addr_a];
        o_read_data_b = regs_reg[i_read_addr_b];
        if (write_now && (i_read_addr_a == i_write_addr)) o_read_data_a = wb_data_next;
        if (write_now && (i_read_addr_b == i_write_addr)) o_read_data_b = wb_data_next;
    end
`else
    always_comb begin
        o_read_data_a = regs_reg[i_read_addr_a];
        o_read_data_b = regs_reg[i_read_addr_b];
    end
`endif

    // Address/data stay put on idle cycles so the forwarding unit only has to watch valid.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            fwd_valid_reg <= 1'b0;
            fwd_addr_reg  <= '0;
            fwd_data_reg  <= '0;
        end else begin
            fwd_valid_reg <= i_write_back;
            if (i_write_back) begin
                fwd_addr_reg <= i_write_addr;
                fwd_data_reg <= wb_data_next;
            end
        end
    end

    assign o_fwd_valid = fwd_valid_reg;
    assign o_fwd_addr  = fwd_addr_reg;
    assign o_fwd_data  = fwd_data_reg;
endmodule

// File: tb/tb_write_back_regfile.sv
// Directed bench for write_back_regfile: reference model compared every cycle plus literal checks.
// Honours WB_BYPASS_EN the same way as the design build.
module tb_write_back_regfile;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [DATA_W-1:0] ex = '0, mem = '0, imm = '0, prt = '0;
    logic [1:0]        sel = '0;
    logic              we = 1'b0;
    logic [ADDR_W-1:0] wa = '0, ra = '0, rb = '0;
    logic [DATA_W-1:0] rda, rdb, wbd, fdata;
    logic              fvalid;
    logic [ADDR_W-1:0] faddr;

    int checks = 0;
    int failures = 0;
    bit check_en = 1'b0;

    // Reference state
    logic [DATA_W-1:0] m_regs [8];
    logic              m_fvalid;
    logic [ADDR_W-1:0] m_faddr;
    logic [DATA_W-1:0] m_fdata;

    write_back_regfile #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .i_clk(clk), .i_reset(rst),
        .i_ex_result(ex), .i_memory_data(mem), .i_immediate(imm), .i_port(prt),
        .i_wb_selector(sel), .i_write_back(we), .i_write_addr(wa),
        .i_read_addr_a(ra), .i_read_addr_b(rb),
        .o_read_data_a(rda), .o_read_data_b(rdb), .o_wb_data(wbd),
        .o_fwd_valid(fvalid), .o_fwd_addr(faddr), .o_fwd_data(fdata)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] exp_wb();
        logic [DATA_W-1:0] src [4];
        src[0] = ex; src[1] = mem; src[2] = imm; src[3] = prt;
        return src[sel];
    endfunction

    function automatic logic [DATA_W-1:0] exp_read(input logic [ADDR_W-1:0] a);
`ifdef WB_BYPASS_EN
        if (we && !rst && a == wa) return exp_wb();
`endif
        return m_regs[a];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, expv, $time);
        end
    endtask

    // Model update at each rising edge
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) m_regs[i] = '0;
            m_fvalid = 1'b0; m_faddr = '0; m_fdata = '0;
        end else begin
            m_fvalid = we;
            if (we) begin
                m_regs[wa] = exp_wb();
                m_faddr = wa;
                m_fdata = exp_wb();
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (check_en) begin
            check("wb_data", 32'(wbd), 32'(exp_wb()));
            check("read_a", 32'(rda), 32'(exp_read(ra)));
            check("read_b", 32'(rdb), 32'(exp_read(rb)));
            check("fwd_valid", 32'(fvalid), 32'(m_fvalid));
            check("fwd_addr", 32'(faddr), 32'(m_faddr));
            check("fwd_data", 32'(fdata), 32'(m_fdata));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] s, input logic [ADDR_W-1:0] a);
        sel = s; wa = a; we = 1'b1;
    endtask

    initial begin
        logic [ADDR_W-1:0] dst [3];
        logic [DATA_W-1:0] val [3];
        dst[0] = 3'd1; dst[1] = 3'd2; dst[2] = 3'd7;
        val[0] = 16'hAAAA; val[1] = 16'h0055; val[2] = 16'hBEEF;

        rst = 1'b1;
        tick(); tick();
        check_en = 1'b1;
        #2;
        check("reset_fwd_valid", 32'(fvalid), 32'd0);
        check("reset_r3", 32'(rda), 32'd0);
        rst = 1'b0;

        // Single ex_result write to r3
        ex = 16'h1234; wr(2'b00, 3'd3); ra = 3'd3;
        tick();
        we = 1'b0; #2;
        check("r3_after_write", 32'(rda), 32'h1234);
        check("fwd_valid_r3", 32'(fvalid), 32'd1);
        check("fwd_addr_r3", 32'(faddr), 32'd3);
        check("fwd_data_r3", 32'(fdata), 32'h1234);

        // Selector sweep
        mem = 16'hAAAA; imm = 16'h0055; prt = 16'hBEEF;
        for (int i = 0; i < 3; i++) begin
            wr(2'(i + 1), dst[i]); #2;
            check("wb_sel_sweep", 32'(wbd), 32'(val[i]));
            tick();
        end
        we = 1'b0; ra = 3'd1; rb = 3'd2; #2;
        check("r1_mem", 32'(rda), 32'hAAAA);
        check("r2_imm", 32'(rdb), 32'h0055);
        ra = 3'd7; #2;
        check("r7_port", 32'(rda), 32'hBEEF);

        // Same-cycle read of the write target
        ex = 16'h00FF; wr(2'b00, 3'd5); ra = 3'd5; #2;
`ifdef WB_BYPASS_EN
        check("r5_same_cycle", 32'(rda), 32'h00FF);
`else
        check("r5_same_cycle", 32'(rda), 32'h0000);
`endif
        tick();
        we = 1'b0; #2;
        check("r5_next_cycle", 32'(rda), 32'h00FF);

        // Idle cycle: fwd address/data hold
        ex = 16'hFFFF; sel = 2'b00; wa = 3'd6; we = 1'b0; ra = 3'd6;
        tick(); #2;
        check("r6_unchanged", 32'(rda), 32'h0000);
        check("idle_fwd_valid", 32'(fvalid), 32'd0);
        check("idle_fwd_addr", 32'(faddr), 32'd5);
        check("idle_fwd_data", 32'(fdata), 32'h00FF);

        // Back-to-back writes to r0
        ex = 16'h1111; wr(2'b00, 3'd0); tick();
        ex = 16'h2222; tick();
        we = 1'b0; ra = 3'd0; rb = 3'd0; #2;
        check("r0_a_last", 32'(rda), 32'h2222);
        check("r0_b_last", 32'(rdb), 32'h2222);

        // Reset overrides a simultaneous write
        ex = 16'h4444; wr(2'b00, 3'd4); tick();
        ex = 16'h7777; rst = 1'b1; tick();
        rst = 1'b0; we = 1'b0; ra = 3'd4; rb = 3'd7; #2;
        check("r4_reset_drop", 32'(rda), 32'h0000);
        check("r7_reset_clear", 32'(rdb), 32'h0000);
        check("reset_fwd_valid2", 32'(fvalid), 32'd0);
        check("reset_fwd_data", 32'(fdata), 32'h0000);

        // Write in first cycle after reset release
        rst = 1'b1; tick();
        rst = 1'b0; imm = 16'h0ABC; wr(2'b10, 3'd2); tick();
        we = 1'b0; ra = 3'd2; #2;
        check("post_reset_write", 32'(rda), 32'h0ABC);
        check("post_reset_fwd", 32'(fdata), 32'h0ABC);

        tick(); tick();
        check_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
